dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-ported data memory between two requesters: port A (CPU
// load/store) and port B (loader/debug). Accesses move through a grant stage,
// a memory stage and a response stage, so a request granted in cycle N drives
// the memory in N+1 and returns its response in N+2. One access per cycle,
// responses in grant order.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   port A request (valid, write, byte addr, data)
//   a_ack                       port A request accepted this cycle (comb.)
//   a_rvalid/a_rdata/a_err      port A response pulse, read data, misalign err
//   b_*                         same set for port B
//   mem_access_addr/mem_in      word-aligned address and write data to memory
//   mem_write_en/mem_read_en    memory strobes
//   mem_out                     combinational read data from memory
//
// Parameter FIXED_PRIO: 0 = round-robin, 1 = port A always wins.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,

    output logic [31:0] mem_access_addr,
    output logic [31:0] mem_in,
    output logic        mem_write_en,
    output logic        mem_read_en,
    input  logic [31:0] mem_out
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Access sitting in the memory stage.
    typedef struct packed {
        logic        valid;
        port_e       port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_stage_t;

    // Response waiting to be presented to its owner.
    typedef struct packed {
        logic        valid;
        port_e       port;
        logic        err;
        logic [31:0] rdata;
    } rsp_stage_t;

    mem_stage_t ms_q, ms_d;
    rsp_stage_t rs_q, rs_d;
    logic       last_b_q, last_b_d;   // 1 = port B received the most recent grant

    logic       grant_a;
    logic       grant_b;
    logic       ms_aligned;
    logic       ms_active;

    // -----------------------------------------------------------------------
    // Grant stage
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (FIXED_PRIO) begin
                grant_a = a_req;
                grant_b = b_req & ~a_req;
            end else if (a_req && b_req) begin
                // Contention: whoever was not served last goes first.
                grant_a = last_b_q;
                grant_b = ~last_b_q;
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

    assign a_ack = grant_a;
    assign b_ack = grant_b;

    // -----------------------------------------------------------------------
    // Next-state logic for both pipeline stages and the grant pointer
    // -----------------------------------------------------------------------
    assign ms_aligned = (ms_q.addr[1:0] == 2'b00);

    always_comb begin
        ms_d       = '0;
        ms_d.valid = grant_a | grant_b;
        ms_d.port  = grant_b ? PORT_B : PORT_A;
        ms_d.we    = grant_b ? b_we    : a_we;
        ms_d.addr  = grant_b ? b_addr  : a_addr;
        ms_d.wdata = grant_b ? b_wdata : a_wdata;

        last_b_d = last_b_q;
        if (grant_a) begin
            last_b_d = 1'b0;
        end else if (grant_b) begin
            last_b_d = 1'b1;
        end

        // Read data is captured at the end of the memory-stage cycle; writes
        // and misaligned accesses answer with zero data.
        rs_d       = '0;
        rs_d.valid = ms_q.valid;
        rs_d.port  = ms_q.port;
        rs_d.err   = ms_q.valid & ~ms_aligned;
        if (ms_q.valid && !ms_q.we && ms_aligned) begin
            rs_d.rdata = mem_out;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: only the valid bit of the memory stage is reset; its payload
            // is ignored while invalid, so it needs no reset.
            ms_q.valid <= 1'b0;
            rs_q       <= '0;
            last_b_q   <= 1'b1;   // first contended grant after reset goes to A
        end else begin
            ms_q     <= ms_d;
            rs_q     <= rs_d;
            last_b_q <= last_b_d;
        end
    end

    // -----------------------------------------------------------------------
    // Memory stage outputs
    // -----------------------------------------------------------------------
    // Strobes are blocked combinationally during reset so a write caught in
    // flight at the reset edge never reaches the memory.
    assign ms_active       = ms_q.valid & ms_aligned & ~reset;
    assign mem_read_en     = ms_active & ~ms_q.we;
    assign mem_write_en    = ms_active &  ms_q.we;
    assign mem_access_addr = ms_q.valid ? {ms_q.addr[31:2], 2'b00} : '0;
    assign mem_in          = ms_q.valid ? ms_q.wdata : '0;

    // -----------------------------------------------------------------------
    // Response stage outputs: only the owning port sees the pulse
    // -----------------------------------------------------------------------
    assign a_rvalid = rs_q.valid & (rs_q.port == PORT_A);
    assign b_rvalid = rs_q.valid & (rs_q.port == PORT_B);
    assign a_rdata  = a_rvalid ? rs_q.rdata : '0;
    assign b_rdata  = b_rvalid ? rs_q.rdata : '0;
    assign a_err    = a_rvalid & rs_q.err;
    assign b_err    = b_rvalid & rs_q.err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives one round-robin instance and one fixed-priority instance with the
// same request stream. Each instance has its own behavioural data memory.
// A reference model predicts the acks and memory strobes every cycle and
// pushes expected responses into a per-instance scoreboard queue when an
// access leaves the memory stage; responses are popped and compared when due.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    typedef struct {
        logic        port;     // 0 = A, 1 = B
        logic        err;
        logic [31:0] rdata;
        int          due;      // cycle in which the rvalid pulse is expected
    } rsp_t;

    typedef struct {
        logic        valid;
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        preload;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;

    logic        a_ack_w    [2];
    logic        a_rvalid_w [2];
    logic [31:0] a_rdata_w  [2];
    logic        a_err_w    [2];
    logic        b_ack_w    [2];
    logic        b_rvalid_w [2];
    logic [31:0] b_rdata_w  [2];
    logic        b_err_w    [2];
    logic [31:0] mem_addr_w [2];
    logic [31:0] mem_in_w   [2];
    logic        mem_we_w   [2];
    logic        mem_re_w   [2];
    logic [31:0] mem_out_w  [2];

    logic [31:0] dmem0 [256];
    logic [31:0] dmem1 [256];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;

    rsp_t        sb_q0[$];
    rsp_t        sb_q1[$];
    logic [31:0] model_mem [2][256];
    acc_t        ms_m      [2];
    logic        last_b_m  [2];

    always #5 clk = ~clk;

    dmem_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack_w[0]), .a_rvalid(a_rvalid_w[0]), .a_rdata(a_rdata_w[0]), .a_err(a_err_w[0]),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack_w[0]), .b_rvalid(b_rvalid_w[0]), .b_rdata(b_rdata_w[0]), .b_err(b_err_w[0]),
        .mem_access_addr(mem_addr_w[0]), .mem_in(mem_in_w[0]),
        .mem_write_en(mem_we_w[0]), .mem_read_en(mem_re_w[0]), .mem_out(mem_out_w[0])
    );

    dmem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack_w[1]), .a_rvalid(a_rvalid_w[1]), .a_rdata(a_rdata_w[1]), .a_err(a_err_w[1]),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack_w[1]), .b_rvalid(b_rvalid_w[1]), .b_rdata(b_rdata_w[1]), .b_err(b_err_w[1]),
        .mem_access_addr(mem_addr_w[1]), .mem_in(mem_in_w[1]),
        .mem_write_en(mem_we_w[1]), .mem_read_en(mem_re_w[1]), .mem_out(mem_out_w[1])
    );

    function automatic logic [31:0] init_word(input int i);
        return {8'hA5, 8'(i), 16'(i * 7)};
    endfunction

    // Behavioural data memories: combinational read, write at the clock edge.
    assign mem_out_w[0] = dmem0[mem_addr_w[0][9:2]];
    assign mem_out_w[1] = dmem1[mem_addr_w[1][9:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                dmem0[i] <= init_word(i);
                dmem1[i] <= init_word(i);
            end
        end else begin
            if (mem_we_w[0]) dmem0[mem_addr_w[0][9:2]] <= mem_in_w[0];
            if (mem_we_w[1]) dmem1[mem_addr_w[1][9:2]] <= mem_in_w[1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    // Compare one instance against the model for the current cycle, then
    // advance the model across the coming clock edge.
    task automatic eval_dut(input int d);
        logic  exp_a, exp_b, aligned, has_rsp;
        rsp_t  r;
        acc_t  nxt;
        string p;

        p     = (d == 0) ? "rr" : "fp";
        exp_a = 1'b0;
        exp_b = 1'b0;
        if (!reset) begin
            if (d == 1 || !(a_req && b_req)) begin
                exp_a = a_req;
                exp_b = b_req && !a_req;
            end else begin
                exp_a = last_b_m[d];
                exp_b = !last_b_m[d];
            end
        end
        check({p, " a_ack"}, 32'(a_ack_w[d]), 32'(exp_a));
        check({p, " b_ack"}, 32'(b_ack_w[d]), 32'(exp_b));

        aligned = (ms_m[d].addr[1:0] == 2'b00);
        check({p, " mem_read_en"},  32'(mem_re_w[d]),
              32'(ms_m[d].valid && !ms_m[d].we && aligned && !reset));
        check({p, " mem_write_en"}, 32'(mem_we_w[d]),
              32'(ms_m[d].valid &&  ms_m[d].we && aligned && !reset));
        check({p, " mem_access_addr"}, mem_addr_w[d],
              ms_m[d].valid ? {ms_m[d].addr[31:2], 2'b00} : 32'h0);
        check({p, " mem_in"}, mem_in_w[d], ms_m[d].valid ? ms_m[d].wdata : 32'h0);

        has_rsp = 1'b0;
        r       = '{port: 1'b0, err: 1'b0, rdata: 32'h0, due: 0};
        if (d == 0 && sb_q0.size() > 0 && sb_q0[0].due == cyc) begin
            r = sb_q0.pop_front();
            has_rsp = 1'b1;
        end
        if (d == 1 && sb_q1.size() > 0 && sb_q1[0].due == cyc) begin
            r = sb_q1.pop_front();
            has_rsp = 1'b1;
        end
        check({p, " a_rvalid"}, 32'(a_rvalid_w[d]), 32'(has_rsp && !r.port));
        check({p, " b_rvalid"}, 32'(b_rvalid_w[d]), 32'(has_rsp &&  r.port));
        if (has_rsp && !r.port) begin
            check({p, " a_rdata"}, a_rdata_w[d], r.rdata);
            check({p, " a_err"},   32'(a_err_w[d]), 32'(r.err));
        end
        if (has_rsp && r.port) begin
            check({p, " b_rdata"}, b_rdata_w[d], r.rdata);
            check({p, " b_err"},   32'(b_err_w[d]), 32'(r.err));
        end
        if (!has_rsp && !ms_m[d].valid) begin
            check({p, " idle a_rdata"}, a_rdata_w[d], 32'h0);
            check({p, " idle b_rdata"}, b_rdata_w[d], 32'h0);
            check({p, " idle err"},     32'({a_err_w[d], b_err_w[d]}), 32'h0);
        end

        if (reset) begin
            ms_m[d].valid = 1'b0;
            last_b_m[d]   = 1'b1;
            if (d == 0) sb_q0.delete(); else sb_q1.delete();
        end else begin
            if (ms_m[d].valid) begin
                r.port  = ms_m[d].port;
                r.err   = !aligned;
                r.rdata = (!ms_m[d].we && aligned) ? model_mem[d][ms_m[d].addr[9:2]] : 32'h0;
                r.due   = cyc + 1;
                if (ms_m[d].we && aligned) model_mem[d][ms_m[d].addr[9:2]] = ms_m[d].wdata;
                if (d == 0) sb_q0.push_back(r); else sb_q1.push_back(r);
            end
            nxt.valid = exp_a || exp_b;
            nxt.port  = exp_b;
            nxt.we    = exp_b ? b_we    : a_we;
            nxt.addr  = exp_b ? b_addr  : a_addr;
            nxt.wdata = exp_b ? b_wdata : a_wdata;
            ms_m[d]   = nxt;
            if (exp_a)      last_b_m[d] = 1'b0;
            else if (exp_b) last_b_m[d] = 1'b1;
        end
    endtask

    // One clock cycle: apply inputs after the edge, check mid-cycle.
    task automatic drive(input logic r,
                         input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                         input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
        reset = r;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        @(negedge clk);
        eval_dut(0);
        eval_dut(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; preload = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) model_mem[d][i] = init_word(i);
            ms_m[d]     = '{valid: 1'b0, port: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0};
            last_b_m[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        preload = 1'b0;

        // Requests during reset must not be accepted.
        drive(1'b1, 1'b1, 1'b1, 32'h40, 32'h1111_1111, 1'b1, 1'b1, 32'h44, 32'h2222_2222);
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0,         1'b1, 1'b0, 32'h44, 32'h0);
        idle(1);

        // A write 0x08 then A read 0x08 in the next cycle.
        drive(1'b0, 1'b1, 1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h08, 32'h0,         1'b0, 1'b0, 32'h0, 32'h0);
        idle(3);

        // Both ports requesting for 4 cycles right after reset, then A drops.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, 1'b0, 32'(16 * i), 32'h0, 1'b1, 1'b0, 32'(16 * i + 4), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
        idle(3);

        // Misaligned B write: error response, memory word 0x08 untouched.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0A, 32'h1234_5678);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(3);

        // Write killed by reset in its memory stage; a later read sees old data.
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);
        drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 1'b0, 32'h0, 32'h0);
        idle(3);

        // Random mixed traffic with occasional misalignment and reset.
        for (int i = 0; i < 400; i++) begin
            logic        rr, ar, aw, br, bw;
            logic [31:0] aa, ad, ba, bd;
            rr = ($urandom_range(0, 59) == 0);
            ar = 1'($urandom_range(0, 1));
            aw = 1'($urandom_range(0, 1));
            br = 1'($urandom_range(0, 1));
            bw = 1'($urandom_range(0, 1));
            aa = {22'd0, 8'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
            ba = {22'd0, 8'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
            ad = $urandom;
            bd = $urandom;
            drive(rr, ar, aw, aa, ad, br, bw, ba, bd);
        end
        idle(4);

        check("rr scoreboard drained", 32'(sb_q0.size()), 32'h0);
        check("fp scoreboard drained", 32'(sb_q1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
